// File: rtl/conv_window_feeder_pkg.sv
// Shared types and sizing helpers for the convolution front end and the dot-product array.
package ttpu_conv_pkg;
  localparam int DATA_WIDTH_DEF = 16;
  localparam int NUM_UNITS_DEF  = 4;

  localparam logic [1:0] SEL_IMG  = 2'd0;
  localparam logic [1:0] SEL_KER  = 2'd1;
  localparam logic [1:0] SEL_BIAS = 2'd2;

  typedef logic [NUM_UNITS_DEF-1:0][DATA_WIDTH_DEF-1:0] vector_t;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_STREAM, S_WAIT_DONE, S_FINISH} fsm_state_e;

  function automatic int out_width(int image_width, int kernel_size);
    return image_width - kernel_size + 1;
  endfunction

  function automatic int num_groups(int image_width, int kernel_size, int num_units);
    int ow;
    ow = out_width(image_width, kernel_size);
    return (ow * ow + num_units - 1) / num_units;
  endfunction

  function automatic int cw(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/conv_window_feeder_if.sv
// Load port, pass control and per-tap vector stream between host, feeder and dot-product array.
interface conv_window_feeder_if #(
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_UNITS   = 4,
  parameter int IMAGE_WIDTH = 5,
  parameter int KERNEL_SIZE = 3
);
  localparam int AW = $clog2(IMAGE_WIDTH * IMAGE_WIDTH);
  localparam int LW = $clog2(KERNEL_SIZE * KERNEL_SIZE + 1);

  logic                                 load_en;
  logic [1:0]                           load_sel;
  logic [AW-1:0]                        load_addr;
  logic [DATA_WIDTH-1:0]                load_data;
  logic                                 start;
  logic                                 busy;
  logic                                 all_done;
  logic                                 dp_start;
  logic [NUM_UNITS-1:0]                 active_units;
  logic [LW-1:0]                        length;
  logic [NUM_UNITS-1:0][DATA_WIDTH-1:0] a_out_array;
  logic [NUM_UNITS-1:0][DATA_WIDTH-1:0] b_out_array;
  logic [NUM_UNITS-1:0][DATA_WIDTH-1:0] bias_array;
  logic                                 array_done;
  logic                                 done;

  modport master (
    output load_en, load_sel, load_addr, load_data, start, array_done, done,
    input  busy, all_done, dp_start, active_units, length, a_out_array, b_out_array, bias_array
  );
  modport slave (
    input  load_en, load_sel, load_addr, load_data, start, array_done, done,
    output busy, all_done, dp_start, active_units, length, a_out_array, b_out_array, bias_array
  );
endinterface

// File: rtl/conv_window_feeder_addr_gen.sv
// Group/tap counters and per-unit image addresses for the next vector; addresses track the
// counters' next state so the top can register the vector on the same edge the counters move.
module conv_addr_gen
  import ttpu_conv_pkg::*;
#(
  parameter int NUM_UNITS   = 4,
  parameter int IMAGE_WIDTH = 5,
  parameter int KERNEL_SIZE = 3,
  parameter int AW          = $clog2(IMAGE_WIDTH * IMAGE_WIDTH),
  parameter int TW          = cw(KERNEL_SIZE * KERNEL_SIZE)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear,
  input  logic                          adv_tap,
  input  logic                          adv_grp,
  output logic [NUM_UNITS-1:0][AW-1:0]  addr,
  output logic [NUM_UNITS-1:0]          valid,
  output logic [TW-1:0]                 tap_nxt,
  output logic                          tap_last,
  output logic                          grp_last
);
  localparam int OUT_W  = out_width(IMAGE_WIDTH, KERNEL_SIZE);
  localparam int KK     = KERNEL_SIZE * KERNEL_SIZE;
  localparam int NG     = num_groups(IMAGE_WIDTH, KERNEL_SIZE, NUM_UNITS);
  localparam int GW     = cw(NG);
  localparam int KW     = cw(KERNEL_SIZE);
  localparam int RW     = $clog2(OUT_W + NUM_UNITS + 2);
  localparam int STEP_R = NUM_UNITS / OUT_W;
  localparam int STEP_C = NUM_UNITS % OUT_W;

  logic [GW-1:0] grp_q, grp_d;
  logic [TW-1:0] tap_q, tap_d;
  logic [KW-1:0] kr_q, kr_d, kc_q, kc_d;
  logic [RW-1:0] r0_q, r0_d, c0_q, c0_d, c_step;

  always_comb begin
    grp_d  = grp_q;
    tap_d  = tap_q;
    kr_d   = kr_q;
    kc_d   = kc_q;
    r0_d   = r0_q;
    c0_d   = c0_q;
    c_step = c0_q + RW'(STEP_C);
    if (clear) begin
      grp_d = '0; tap_d = '0; kr_d = '0; kc_d = '0; r0_d = '0; c0_d = '0;
    end else if (adv_grp) begin
      // unit-0 pixel moves on by NUM_UNITS: column wraps into the row
      grp_d = grp_q + GW'(1);
      tap_d = '0; kr_d = '0; kc_d = '0;
      if (c_step >= RW'(OUT_W)) begin
        c0_d = c_step - RW'(OUT_W);
        r0_d = r0_q + RW'(STEP_R + 1);
      end else begin
        c0_d = c_step;
        r0_d = r0_q + RW'(STEP_R);
      end
    end else if (adv_tap) begin
      tap_d = tap_q + TW'(1);
      if (kc_q == KW'(KERNEL_SIZE - 1)) begin
        kc_d = '0;
        kr_d = kr_q + KW'(1);
      end else begin
        kc_d = kc_q + KW'(1);
      end
    end
  end

  for (genvar u = 0; u < NUM_UNITS; u++) begin : g_unit
    localparam int DR = u / OUT_W;
    localparam int DC = u % OUT_W;
    logic [RW-1:0] c_sum, c_u, r_u;
    logic          wrap;
    assign c_sum    = c0_d + RW'(DC);
    assign wrap     = c_sum >= RW'(OUT_W);
    assign c_u      = wrap ? c_sum - RW'(OUT_W) : c_sum;
    assign r_u      = r0_d + RW'(DR) + (wrap ? RW'(1) : RW'(0));
    assign valid[u] = r_u < RW'(OUT_W);
    assign addr[u]  = AW'((int'(r_u) + int'(kr_d)) * IMAGE_WIDTH + int'(c_u) + int'(kc_d));
  end

  assign tap_nxt  = tap_d;
  assign tap_last = tap_q == TW'(KK - 1);
  assign grp_last = grp_q == GW'(NG - 1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grp_q <= '0; tap_q <= '0; kr_q <= '0; kc_q <= '0; r0_q <= '0; c0_q <= '0;
    end else begin
      grp_q <= grp_d; tap_q <= tap_d; kr_q <= kr_d; kc_q <= kc_d; r0_q <= r0_d; c0_q <= c0_d;
    end
  end
endmodule

// File: rtl/conv_window_feeder.sv
// Image/kernel/bias buffers plus pass FSM; streams valid-conv windows one kernel tap at a time
// to NUM_UNITS dot-product units, one output pixel per unit per group.
module conv_window_feeder
  import ttpu_conv_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_UNITS   = 4,
  parameter int IMAGE_WIDTH = 5,
  parameter int KERNEL_SIZE = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  conv_window_feeder_if.slave  bus
);
  localparam int KK    = KERNEL_SIZE * KERNEL_SIZE;
  localparam int IMG_N = IMAGE_WIDTH * IMAGE_WIDTH;
  localparam int AW    = $clog2(IMG_N);
  localparam int TW    = cw(KK);
  localparam int LW    = $clog2(KK + 1);

  typedef logic [NUM_UNITS-1:0][DATA_WIDTH-1:0] vec_t;

  logic [DATA_WIDTH-1:0] img_mem [IMG_N];
  logic [DATA_WIDTH-1:0] ker_mem [KK];
  logic [DATA_WIDTH-1:0] bias_mem;

  fsm_state_e           state_q, state_d;
  logic                 busy_q, busy_d, all_done_q, all_done_d, dp_start_q, dp_start_d;
  logic [NUM_UNITS-1:0] active_q, active_d;
  vec_t                 a_q, a_d, b_q, b_d, bias_q, bias_d;
  logic                 clear, adv_tap, adv_grp, load_vec, zero_vec, grp_step;
  logic                 wr_img, wr_ker, wr_bias;

  logic [NUM_UNITS-1:0][AW-1:0] addr;
  logic [NUM_UNITS-1:0]         valid;
  logic [TW-1:0]                tap_nxt;
  logic                         tap_last, grp_last;

  conv_addr_gen #(
    .NUM_UNITS(NUM_UNITS), .IMAGE_WIDTH(IMAGE_WIDTH), .KERNEL_SIZE(KERNEL_SIZE), .AW(AW), .TW(TW)
  ) u_addr_gen (
    .clk(clk), .reset(reset), .clear(clear), .adv_tap(adv_tap), .adv_grp(adv_grp),
    .addr(addr), .valid(valid), .tap_nxt(tap_nxt), .tap_last(tap_last), .grp_last(grp_last)
  );

  assign wr_img  = bus.load_en && !busy_q && bus.load_sel == SEL_IMG && int'(bus.load_addr) < IMG_N;
  assign wr_ker  = bus.load_en && !busy_q && bus.load_sel == SEL_KER && int'(bus.load_addr) < KK;
  assign wr_bias = bus.load_en && !busy_q && bus.load_sel == SEL_BIAS;

  // Buffer contents survive reset; only the registered outputs are cleared.
  always_ff @(posedge clk) begin
    if (wr_img)  img_mem[bus.load_addr] <= bus.load_data;
    if (wr_ker)  ker_mem[bus.load_addr[TW-1:0]] <= bus.load_data;
    if (wr_bias) bias_mem <= bus.load_data;
  end

  assign bias_d = wr_bias ? {NUM_UNITS{bus.load_data}} : {NUM_UNITS{bias_mem}};

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    all_done_d = 1'b0;
    dp_start_d = 1'b0;
    clear      = 1'b0;
    adv_tap    = 1'b0;
    adv_grp    = 1'b0;
    load_vec   = 1'b0;
    zero_vec   = 1'b0;
    grp_step   = 1'b0;
    case (state_q)
      S_IDLE: if (bus.start) begin
        state_d = S_ISSUE; busy_d = 1'b1; dp_start_d = 1'b1; clear = 1'b1; load_vec = 1'b1;
      end
      S_ISSUE: state_d = S_STREAM;
      S_STREAM: begin
        // done only counts once the last tap is on the bus; extra array_done there just parks
        if (bus.done && tap_last) grp_step = 1'b1;
        else if (bus.array_done) begin
          if (tap_last) state_d = S_WAIT_DONE;
          else begin adv_tap = 1'b1; load_vec = 1'b1; end
        end
      end
      S_WAIT_DONE: grp_step = bus.done;
      S_FINISH: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (grp_step) begin
      if (grp_last) begin
        state_d = S_FINISH; busy_d = 1'b0; all_done_d = 1'b1; zero_vec = 1'b1;
      end else begin
        state_d = S_ISSUE; dp_start_d = 1'b1; adv_grp = 1'b1; load_vec = 1'b1;
      end
    end
  end

  always_comb begin
    active_d = active_q;
    a_d      = a_q;
    b_d      = b_q;
    if (zero_vec) begin
      active_d = '0; a_d = '0; b_d = '0;
    end else if (load_vec) begin
      for (int u = 0; u < NUM_UNITS; u++) begin
        active_d[u] = valid[u];
        a_d[u]      = valid[u] ? img_mem[addr[u]] : '0;
        b_d[u]      = valid[u] ? ker_mem[tap_nxt] : '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE; busy_q <= 1'b0; all_done_q <= 1'b0; dp_start_q <= 1'b0;
      active_q <= '0; a_q <= '0; b_q <= '0; bias_q <= '0;
    end else begin
      state_q <= state_d; busy_q <= busy_d; all_done_q <= all_done_d; dp_start_q <= dp_start_d;
      active_q <= active_d; a_q <= a_d; b_q <= b_d; bias_q <= bias_d;
    end
  end

  assign bus.busy         = busy_q;
  assign bus.all_done     = all_done_q;
  assign bus.dp_start     = dp_start_q;
  assign bus.active_units = active_q;
  assign bus.length       = LW'(KK);
  assign bus.a_out_array  = a_q;
  assign bus.b_out_array  = b_q;
  assign bus.bias_array   = bias_q;
endmodule

// File: tb/tb_conv_window_feeder.sv
// Bench for conv_window_feeder: table-driven full pass plus busy/reset corner sequences,
// expected vectors from an independent div/mod im2col model through a scoreboard queue.
module tb_conv_window_feeder;
  import ttpu_conv_pkg::*;

  localparam int DW = 16, NU = 4, IW = 5, K = 3, OW = 3, KK = 9;

  typedef vector_t vec_t;
  typedef struct { bit st; bit ad; bit dn; int grp; int tap; bit on; bit dp; bit busy; bit alld; } row_t;
  typedef struct { string name; bit dp; bit busy; bit alld; logic [NU-1:0] act; vec_t a; vec_t b; vec_t bias; } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  conv_window_feeder_if #(.DATA_WIDTH(DW), .NUM_UNITS(NU), .IMAGE_WIDTH(IW), .KERNEL_SIZE(K)) bus ();
  conv_window_feeder #(.DATA_WIDTH(DW), .NUM_UNITS(NU), .IMAGE_WIDTH(IW), .KERNEL_SIZE(K)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  row_t            tbl[$];
  exp_t            sb[$];
  logic [DW-1:0]   img_m [IW*IW];
  logic [DW-1:0]   ker_m [KK];
  logic [DW-1:0]   bias_m;
  int n_vec = 0, n_miss = 0, dp_cnt = 0, dp_base = 0;

  always @(negedge clk) if (bus.dp_start === 1'b1) dp_cnt++;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic void add(bit st, bit ad, bit dn, int grp, int tap, bit on, bit dp, bit busy, bit alld);
    row_t r;
    r.st = st; r.ad = ad; r.dn = dn; r.grp = grp; r.tap = tap; r.on = on; r.dp = dp; r.busy = busy; r.alld = alld;
    tbl.push_back(r);
  endfunction

  function automatic void push_exp(string name, int grp, int tap, bit on, bit dp, bit busy, bit alld, logic [DW-1:0] bias);
    exp_t e;
    int p, r, c;
    e.name = name; e.dp = dp; e.busy = busy; e.alld = alld;
    e.act = '0; e.a = '0; e.b = '0; e.bias = {NU{bias}};
    if (on) begin
      for (int u = 0; u < NU; u++) begin
        p = grp * NU + u;
        if (p < OW * OW) begin
          r = p / OW; c = p % OW;
          e.act[u] = 1'b1;
          e.a[u]   = img_m[(r + tap / K) * IW + c + tap % K];
          e.b[u]   = ker_m[tap];
        end
      end
    end
    sb.push_back(e);
  endfunction

  task automatic check_out();
    exp_t e;
    n_vec++;
    if (sb.size() == 0) begin
      n_miss++;
      $display("FAIL scoreboard: no expected entry queued");
      return;
    end
    e = sb.pop_front();
    if (bus.dp_start !== e.dp || bus.busy !== e.busy || bus.all_done !== e.alld ||
        bus.active_units !== e.act || bus.a_out_array !== e.a || bus.b_out_array !== e.b ||
        bus.bias_array !== e.bias) begin
      n_miss++;
      $display("FAIL %s: got dp=%b busy=%b alld=%b act=%b a=%h b=%h bias=%h / want dp=%b busy=%b alld=%b act=%b a=%h b=%h bias=%h",
               e.name, bus.dp_start, bus.busy, bus.all_done, bus.active_units, bus.a_out_array,
               bus.b_out_array, bus.bias_array, e.dp, e.busy, e.alld, e.act, e.a, e.b, e.bias);
    end
  endtask

  task automatic step(bit st, bit ad, bit dn);
    bus.start = st; bus.array_done = ad; bus.done = dn;
    @(negedge clk);
    bus.start = 1'b0; bus.array_done = 1'b0; bus.done = 1'b0;
  endtask

  task automatic load(logic [1:0] sel, int addr, logic [DW-1:0] d);
    bus.load_en = 1'b1; bus.load_sel = sel; bus.load_addr = 5'(addr); bus.load_data = d;
    @(negedge clk);
    bus.load_en = 1'b0;
  endtask

  initial begin
    bus.load_en = 1'b0; bus.load_sel = 2'd0; bus.load_addr = '0; bus.load_data = '0;
    bus.start = 1'b0; bus.array_done = 1'b0; bus.done = 1'b0;
    bias_m = 16'h3800;
    for (int i = 0; i < IW * IW; i++) img_m[i] = 16'(i);
    for (int t = 0; t < KK; t++) ker_m[t] = 16'h0064 + 16'(t);

    // Full pass: group 0 plain with a parked 9th array_done, group 1 with an early done and a
    // same-cycle last array_done/done, group 2 partial with a stray start at finish.
    add(1,0,0, 0,0, 1,1,1,0);
    add(0,0,0, 0,0, 1,0,1,0);
    for (int t = 1; t < KK; t++) add(0,1,0, 0,t, 1,0,1,0);
    add(0,0,0, 0,8, 1,0,1,0);
    add(0,1,0, 0,8, 1,0,1,0);
    add(0,0,1, 1,0, 1,1,1,0);
    add(0,0,0, 1,0, 1,0,1,0);
    for (int t = 1; t <= 3; t++) add(0,1,0, 1,t, 1,0,1,0);
    add(0,0,1, 1,3, 1,0,1,0);
    for (int t = 4; t < KK; t++) add(0,1,0, 1,t, 1,0,1,0);
    add(0,1,1, 2,0, 1,1,1,0);
    add(0,0,0, 2,0, 1,0,1,0);
    for (int t = 1; t < KK; t++) add(0,1,0, 2,t, 1,0,1,0);
    add(1,0,1, 0,0, 0,0,0,1);
    add(0,0,0, 0,0, 0,0,0,0);

    @(negedge clk); @(negedge clk);
    push_exp("reset_state", 0,0, 0,0,0,0, 16'h0000); check_out();
    n_vec++;
    if (bus.length !== 4'd9) begin
      n_miss++;
      $display("FAIL length: got %0d want 9", bus.length);
    end
    reset = 1'b0;

    for (int i = 0; i < IW * IW; i++) load(2'd0, i, img_m[i]);
    for (int t = 0; t < KK; t++) load(2'd1, t, ker_m[t]);
    load(2'd3, 0, 16'hDEAD);
    load(2'd2, 0, bias_m);
    push_exp("bias_load", 0,0, 0,0,0,0, bias_m); check_out();

    dp_base = dp_cnt;
    for (int i = 0; i < tbl.size(); i++) begin
      push_exp($sformatf("pass1_row%0d", i), tbl[i].grp, tbl[i].tap, tbl[i].on, tbl[i].dp, tbl[i].busy, tbl[i].alld, bias_m);
      step(tbl[i].st, tbl[i].ad, tbl[i].dn);
      check_out();
    end
    n_vec++;
    if (dp_cnt - dp_base != 3) begin
      n_miss++;
      $display("FAIL dp_start_count: got %0d want 3", dp_cnt - dp_base);
    end

    // Second pass: start and loads while busy must leave no trace.
    push_exp("p2_start", 0,0, 1,1,1,0, bias_m); step(1,0,0); check_out();
    bus.load_en = 1'b1; bus.load_sel = 2'd0; bus.load_addr = '0; bus.load_data = 16'hFFFF;
    push_exp("p2_busy_img_load", 0,0, 1,0,1,0, bias_m); step(1,0,0); bus.load_en = 1'b0; check_out();
    bus.load_en = 1'b1; bus.load_sel = 2'd2; bus.load_data = 16'h1234;
    push_exp("p2_busy_bias_load", 0,1, 1,0,1,0, bias_m); step(0,1,0); bus.load_en = 1'b0; check_out();
    for (int i = 0; i < 7; i++) step(0,1,0);
    step(0,0,1); step(0,0,0);
    for (int i = 0; i < 8; i++) step(0,1,0);
    step(0,0,1); step(0,0,0);
    for (int i = 0; i < 8; i++) step(0,1,0);
    push_exp("p2_finish", 0,0, 0,0,0,1, bias_m); step(0,0,1); check_out();
    step(0,0,0);

    // Third pass: image word 0 unchanged; then reset mid-stream and replay.
    push_exp("p3_start", 0,0, 1,1,1,0, bias_m); step(1,0,0); check_out();
    step(0,0,0); step(0,1,0);
    push_exp("p3_tap2", 0,2, 1,0,1,0, bias_m); step(0,1,0); check_out();
    #2 reset = 1'b1;
    #1;
    push_exp("async_reset", 0,0, 0,0,0,0, 16'h0000); check_out();
    @(negedge clk);
    reset = 1'b0;
    push_exp("post_reset_idle", 0,0, 0,0,0,0, bias_m); step(0,0,0); check_out();
    push_exp("replay_start", 0,0, 1,1,1,0, bias_m); step(1,0,0); check_out();
    push_exp("replay_stream", 0,0, 1,0,1,0, bias_m); step(0,0,0); check_out();
    push_exp("replay_tap1", 0,1, 1,0,1,0, bias_m); step(0,1,0); check_out();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
